pipe_stage_buffer: RTL and testbench

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer_pkg.sv | 29 ++
 rtl/pipe_stage_buffer.sv | 114 +++++++++++
 tb/tb_pipe_stage_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline definitions: stage-buffer state encoding and main-register
// source select, used by every stage register in the pipeline.
package pipe_stage_buffer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_WRITE,
    MAIN_SKID,
    MAIN_CLEAR
  } main_sel_e;

  // Number of held entries implied by a buffer state.
  function automatic logic [1:0] occupancy_of(input buf_state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer used as a pipeline stage register with stall
// backpressure and squash (flush); ready/valid are decoded from state only.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [width-1:0] write_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [width-1:0] read_o,
  input  logic             out_ready_i,
  input  logic             flush_i,
  output logic [1:0]       occupancy_o
);

  buf_state_e       state_q, state_d;
  main_sel_e        main_sel;
  logic             skid_load;
  logic             skid_clear;
  logic             up_xfer;
  logic             down_xfer;
  logic [width-1:0] main_q, main_d;
  logic [width-1:0] skid_q, skid_d;

  // reset_i only masks in_ready_o; neither handshake input reaches an output.
  assign in_ready_o  = (state_q != ST_FULL) && !reset_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign occupancy_o = occupancy_of(state_q);
  assign read_o      = main_q;

  assign up_xfer   = in_valid_i && in_ready_o;
  assign down_xfer = out_valid_o && out_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    main_sel   = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (flush_i) begin
      state_d    = ST_EMPTY;
      main_sel   = MAIN_CLEAR;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            main_sel = MAIN_WRITE;
            state_d  = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (up_xfer && down_xfer) begin
            main_sel = MAIN_WRITE;
          end else if (up_xfer) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (down_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Upstream is already stalled; only a drain can move the skid word up.
          if (out_ready_i) begin
            main_sel = MAIN_SKID;
            state_d  = ST_BUSY;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_sel   = MAIN_CLEAR;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_d = main_q;
    case (main_sel)
      MAIN_WRITE: main_d = write_i;
      MAIN_SKID:  main_d = skid_q;
      MAIN_CLEAR: main_d = '0;
      default:    main_d = main_q;
    endcase

    skid_d = skid_q;
    if (skid_clear) begin
      skid_d = '0;
    end else if (skid_load) begin
      skid_d = write_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      // NOTE: data registers are reset too, because read_o must read 0 after reset.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer: a queue-based capacity-2 FIFO model and a
// negedge monitor that compares every cycle; directed and random stimulus.
module tb_pipe_stage_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         in_valid_i;
  logic [W-1:0] write_i;
  logic         in_ready_o;
  logic         out_valid_o;
  logic [W-1:0] read_o;
  logic         out_ready_i;
  logic         flush_i;
  logic [1:0]   occupancy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] delivered[$];
  logic [W-1:0] idle_val = '0;
  int           max_occ  = 0;

  pipe_stage_buffer #(.width(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .write_i     (write_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .read_o      (read_o),
    .out_ready_i (out_ready_i),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge and hold for the whole cycle.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r,
                       input bit f, input bit rst);
    in_valid_i  = v;
    write_i     = d;
    out_ready_i = r;
    flush_i     = f;
    reset_i     = rst;
    @(posedge clk);
    #1;
  endtask

  // Monitor: at negedge the inputs for the coming edge are stable, so the
  // model both checks the outputs and predicts which transfers will happen.
  initial begin
    logic [W-1:0] v;
    bit           do_pop;
    bit           do_push;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("in_ready", W'(in_ready_o), W'(!reset_i && model_q.size() < 2));
      check("out_valid", W'(out_valid_o), W'(model_q.size() > 0));
      check("occupancy", W'(occupancy_o), W'(model_q.size()));
      check("read_data", read_o, (model_q.size() > 0) ? model_q[0] : idle_val);
      if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);

      if (reset_i || flush_i) begin
        model_q.delete();
        idle_val = '0;
      end else begin
        do_pop  = out_ready_i && (model_q.size() > 0);
        do_push = in_valid_i && (model_q.size() < 2);
        if (do_pop) begin
          v        = model_q.pop_front();
          idle_val = v;
          delivered.push_back(read_o);
        end
        if (do_push) model_q.push_back(write_i);
      end
    end
  end

  initial begin
    in_valid_i  = 1'b0;
    write_i     = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    reset_i     = 1'b1;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready_during", W'(in_ready_o), W'(1'b0));
    reset_i = 1'b0;
    #1;
    check("reset_in_ready_after", W'(in_ready_o), W'(1'b1));
    check("reset_read", read_o, '0);
    check("reset_occupancy", W'(occupancy_o), '0);
    check("reset_out_valid", W'(out_valid_o), '0);

    // Single word through an empty buffer.
    delivered.delete();
    drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    check("single_read", read_o, 32'hA5A5_0001);
    check("single_valid", W'(out_valid_o), W'(1'b1));
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("single_count", W'(delivered.size()), W'(1));
    check("single_empty", W'(occupancy_o), '0);

    // Stall fill: third word must bounce off a full buffer.
    delivered.delete();
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    check("stall_full", W'(occupancy_o), W'(2));
    check("stall_in_ready", W'(in_ready_o), W'(1'b0));
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    check("stall_still_full", W'(occupancy_o), W'(2));
    check("stall_hold_read", read_o, 32'h11);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stall_count", W'(delivered.size()), W'(2));
    if (delivered.size() == 2) begin
      check("stall_first", delivered[0], 32'h11);
      check("stall_second", delivered[1], 32'h22);
    end

    // Streaming at full throughput.
    delivered.delete();
    max_occ = 0;
    for (int i = 0; i < 100; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stream_count", W'(delivered.size()), W'(100));
    for (int i = 0; i < delivered.size(); i++) check("stream_order", delivered[i], W'(i));
    check("stream_max_occ_lt2", W'(max_occ < 2), W'(1'b1));

    // Flush while full, with both handshakes asserted.
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    check("flush_pre_full", W'(occupancy_o), W'(2));
    delivered.delete();
    drive(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    check("flush_occupancy", W'(occupancy_o), '0);
    check("flush_read", read_o, '0);
    check("flush_out_valid", W'(out_valid_o), '0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_no_delivery", W'(delivered.size()), '0);

    // Random backpressure with rare flush and rare mid-run reset.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) == 0));
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", W'(occupancy_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
